serial_sub: RTL
===============

Name: serial_sub

Overview:
Bit-serial N-bit subtractor. It computes difference = a - b - borrowIn one bit per clock, LSB first. It uses a single one-bit full-subtractor cell and a registered borrow loop. It sits upstream of wider datapath logic that needs an area-cheap subtract, and it exposes a start/busy/done handshake to its controller.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is 2 or more.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE or DONE.
a  input  WIDTH  minuend; sampled on the accepted start edge.
b  input  WIDTH  subtrahend; sampled on the accepted start edge.
borrowIn  input  1  initial borrow; sampled on the accepted start edge.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse; high while in DONE.
difference  output  WIDTH  registered result; holds until the next result is written.
borrowOut  output  1  registered final borrow; holds with difference.

Behaviour:
- Reset: one clk edge with rst=1 forces the following:
  - state=IDLE, busy=0, done=0.
  - difference=0, borrowOut=0.
  - Shift registers, bit counter and borrow flop are all cleared.
- rst has priority over every other input. Asserting it mid-SHIFT aborts the operation; no done pulse and no result update follow.
- States (encoding IDLE=0, SHIFT=1, DONE=2):
  - IDLE: on start=1, load shA<=a, shB<=b, brw<=borrowIn, cnt<=0, then go to SHIFT. If start=0, stay in IDLE.
  - SHIFT, every cycle:
    - The cell takes shA[0], shB[0] and brw as inputs.
    - shA and shB shift right by one bit.
    - Cell difference enters shD at the MSB.
    - brw<=cell borrowOut, cnt<=cnt+1.
    - When cnt==WIDTH-1, go to DONE. In that same edge, write difference<={cell bit, shD[WIDTH-1:1]} and borrowOut<=cell borrowOut.
  - DONE: done=1 for exactly one cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back), going straight to SHIFT.
    - Otherwise go to IDLE.
- start during SHIFT is ignored. a, b and borrowIn may change freely after the accept edge.
- Latency: start accepted at edge E0. busy is high for exactly WIDTH cycles. done is high in the cycle after edge E_WIDTH. Results are valid from that cycle onward.
- Outputs are not glitch-visible: difference and borrowOut change only on the SHIFT->DONE edge or on reset.
- Arithmetic is modulo 2^WIDTH. borrowOut=1 iff a < b + borrowIn, treating the operands as unsigned.
- The counter is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.

Decomposition:
- Shared package/header holds:
  - state encodings S_IDLE, S_SHIFT, S_DONE (2-bit localparams);
  - the counter-width function (clog2).
- One sub-module: the team's existing one-bit structural full subtractor, with ports a, b, borrowIn, difference, borrowOut. It is instantiated once as the serial cell.
- No other hierarchy.

Test Plan:
- Basic subtract (WIDTH=8): a=0x5A, b=0x3C, borrowIn=0, start for 1 cycle.
  - busy is high 8 cycles, then done=1 for 1 cycle.
  - Result: difference=0x1E, borrowOut=0.
- Underflow: a=0x00, b=0x01, borrowIn=0 -> difference=0xFF, borrowOut=1.
- Borrow-in chain: a=0x10, b=0x10, borrowIn=1 -> difference=0xFF, borrowOut=1.
  - Also a=0xFF, b=0x00, borrowIn=1 -> 0xFE, borrowOut=0.
- Start ignored while busy:
  - Start with 0x5A-0x3C.
  - At cycle 3, pulse start with a=0x00, b=0x01.
  - Expected: a single done pulse at the original time, with result 0x1E and borrowOut=0.
- Reset mid-operation:
  - Start 0x80-0x01.
  - Assert rst for 1 cycle at cycle 4.
  - Expected: busy=0, done never pulses, difference=0x00, borrowOut=0.
  - A new start of 0x80-0x01 then gives 0x7F, borrowOut=0.
- Back-to-back: hold start high in the DONE cycle with a=0x03, b=0x05.
  - Expected: SHIFT re-entered with no IDLE cycle.
  - Second done pulse arrives WIDTH+1 cycles after the first, with difference=0xFE, borrowOut=1.
  - The first result holds until that second done.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encodings and width helper for serial_sub
package serial_sub_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_sub_fs.sv
// rtl/serial_sub_fs.sv - one-bit structural full subtractor cell
module serial_sub_fs (
    input  logic a,
    input  logic b,
    input  logic borrowIn,
    output logic difference,
    output logic borrowOut
);

    logic a_xor_b;

    assign a_xor_b    = a ^ b;
    assign difference = a_xor_b ^ borrowIn;
    assign borrowOut  = (~a & b) | (~a_xor_b & borrowIn);

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial a - b - borrowIn, LSB first, start/busy/done handshake
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrowOut
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic cell_diff;
    logic cell_borrow;

    serial_sub_fs u_cell (
        .a          (sha_q[0]),
        .b          (shb_q[0]),
        .borrowIn   (brw_q),
        .difference (cell_diff),
        .borrowOut  (cell_borrow)
    );

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        shd_d   = shd_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts start too, so back-to-back operations skip IDLE
                if (start) begin
                    sha_d   = a;
                    shb_d   = b;
                    brw_d   = borrowIn;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sha_d = sha_q >> 1;
                shb_d = shb_q >> 1;
                shd_d = {cell_diff, shd_q[WIDTH-1:1]};
                brw_d = cell_borrow;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    diff_d  = {cell_diff, shd_q[WIDTH-1:1]};
                    bout_d  = cell_borrow;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            shd_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            shd_q   <= shd_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign difference = diff_q;
    assign borrowOut  = bout_q;

endmodule
